// File: rtl/shim_spi_sts_fault_latch.sv
// Fault latch for synchronized SPI status in the AXI domain.
// Sticky flags, first-fault capture and a timestamped event FIFO.
module shim_spi_sts_fault_latch #(
    parameter int FIFO_DEPTH = 16,
    parameter int TS_WIDTH   = 32
) (
    input  logic                            aclk,
    input  logic                            areset,
    input  logic                            enable,
    input  logic                            clear,
    input  logic                            spi_off,
    input  logic [95:0]                     ch_sts,
    input  logic                            bad_trig_cmd,
    output logic [96:0]                     fault_sticky,
    output logic                            shutdown_req,
    output logic                            first_valid,
    output logic [6:0]                      first_code,
    output logic                            evt_lost,
    output logic                            evt_valid,
    output logic [6+TS_WIDTH:0]             evt_data,
    input  logic                            evt_ready,
    output logic [$clog2(FIFO_DEPTH):0]     evt_count
);

    localparam int NF = 97;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int DW = 7 + TS_WIDTH;
    localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);

    logic [NF-1:0]       prev_q;
    logic [NF-1:0]       pend_q, pend_d;
    logic [NF-1:0]       sticky_q, sticky_d;
    logic                shut_q;
    logic                fv_q, fv_d;
    logic [6:0]          fc_q, fc_d;
    logic                lost_q, lost_d;
    logic [TS_WIDTH-1:0] ts_q, ts_d;
    logic [AW-1:0]       wr_q, wr_d, rd_q, rd_d;
    logic [AW:0]         cnt_q, cnt_d;
    logic [DW-1:0]       mem_q [FIFO_DEPTH];

    logic [NF-1:0] cur, arise, pend_clr, pend_keep;
    logic          armed, pop, push, can_push, lost_hit, fv_base;
    logic [6:0]    sel;

    // Index of the lowest set bit; 0 when the vector is empty.
    function automatic logic [6:0] lowest(input logic [NF-1:0] v);
        logic [6:0] idx;
        idx = '0;
        for (int i = NF - 1; i >= 0; i--) begin
            if (v[i]) idx = 7'(i);
        end
        return idx;
    endfunction

    assign evt_valid    = (cnt_q != '0);
    assign evt_data     = evt_valid ? mem_q[rd_q] : '0;
    assign evt_count    = cnt_q;
    assign fault_sticky = sticky_q;
    assign shutdown_req = shut_q;
    assign first_valid  = fv_q;
    assign first_code   = fc_q;
    assign evt_lost     = lost_q;

    // Rise detection, event encoder and next-state for all flag state.
    always_comb begin
        cur       = {bad_trig_cmd, ch_sts};
        armed     = enable & ~spi_off;
        arise     = armed ? (cur & ~prev_q) : '0;
        pop       = evt_valid & evt_ready & ~clear;
        can_push  = (cnt_q != DEPTH_C) | pop;
        sel       = lowest(pend_q);
        push      = (|pend_q) & can_push & ~clear;
        pend_clr  = push ? (NF'(1) << sel) : '0;
        pend_keep = clear ? '0 : (pend_q & ~pend_clr);
        lost_hit  = |(arise & pend_keep);
        pend_d    = pend_keep | arise;
        sticky_d  = (clear ? '0 : sticky_q) | arise;
        lost_d    = (clear ? 1'b0 : lost_q) | lost_hit;
        fv_base   = clear ? 1'b0 : fv_q;
        if (!fv_base && (|arise)) begin
            fv_d = 1'b1;
            fc_d = lowest(arise);
        end else begin
            fv_d = fv_base;
            fc_d = clear ? 7'd0 : fc_q;
        end
        ts_d = enable ? ts_q + TS_WIDTH'(1) : '0;
    end

    // FIFO pointer and occupancy next-state; clear flushes.
    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (clear) begin
            wr_d  = '0;
            rd_d  = '0;
            cnt_d = '0;
        end else begin
            if (push) wr_d = wr_q + AW'(1);
            if (pop)  rd_d = rd_q + AW'(1);
            unique case ({push, pop})
                2'b10:   cnt_d = cnt_q + (AW+1)'(1);
                2'b01:   cnt_d = cnt_q - (AW+1)'(1);
                default: cnt_d = cnt_q;
            endcase
        end
    end

    // Flag, timestamp and edge-history registers.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            prev_q   <= '0;
            pend_q   <= '0;
            sticky_q <= '0;
            shut_q   <= 1'b0;
            fv_q     <= 1'b0;
            fc_q     <= '0;
            lost_q   <= 1'b0;
            ts_q     <= '0;
        end else begin
            prev_q   <= cur;
            pend_q   <= pend_d;
            sticky_q <= sticky_d;
            shut_q   <= |sticky_d;
            fv_q     <= fv_d;
            fc_q     <= fc_d;
            lost_q   <= lost_d;
            ts_q     <= ts_d;
        end
    end

    // Event FIFO storage and pointers.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
            if (push) mem_q[wr_q] <= {sel, ts_q};
        end
    end

endmodule

// File: tb/tb_shim_spi_sts_fault_latch.sv
// Directed bench for the SPI status fault latch.
// Expected values are hand-derived per scenario.
module tb_shim_spi_sts_fault_latch;

    logic        aclk = 0;
    logic        areset = 1;
    logic        enable = 0;
    logic        clear = 0;
    logic        spi_off = 0;
    logic [95:0] ch_sts = '0;
    logic        bad_trig_cmd = 0;
    logic [96:0] fault_sticky;
    logic        shutdown_req;
    logic        first_valid;
    logic [6:0]  first_code;
    logic        evt_lost;
    logic        evt_valid;
    logic [38:0] evt_data;
    logic        evt_ready = 0;
    logic [4:0]  evt_count;

    int total = 0;
    int bad = 0;
    int ts_m = 0;
    int a;
    int exp_q[$];

    shim_spi_sts_fault_latch #(.FIFO_DEPTH(16), .TS_WIDTH(32)) dut (
        .aclk(aclk), .areset(areset), .enable(enable), .clear(clear),
        .spi_off(spi_off), .ch_sts(ch_sts), .bad_trig_cmd(bad_trig_cmd),
        .fault_sticky(fault_sticky), .shutdown_req(shutdown_req),
        .first_valid(first_valid), .first_code(first_code),
        .evt_lost(evt_lost), .evt_valid(evt_valid), .evt_data(evt_data),
        .evt_ready(evt_ready), .evt_count(evt_count)
    );

    always #5 aclk = ~aclk;

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    // One clock; keeps an independent timestamp model.
    task automatic tick();
        @(posedge aclk);
        if (areset) ts_m = 0;
        else ts_m = enable ? ts_m + 1 : 0;
        #1;
    endtask

    function automatic logic [96:0] b97(input int i);
        logic [96:0] one;
        one = 97'd1;
        return one << i;
    endfunction

    task automatic do_clear();
        clear = 1;
        tick();
        clear = 0;
    endtask

    // Drain with ready high, comparing codes against exp_q in order.
    task automatic drain(input string tag);
        int n;
        int g;
        n = 0;
        g = 0;
        evt_ready = 1;
        while (n < exp_q.size() && g < 60) begin
            if (evt_valid) begin
                chk(tag, evt_data[38:32], exp_q[n]);
                n++;
            end
            tick();
            g++;
        end
        evt_ready = 0;
        chk({tag, "_n"}, n, exp_q.size());
        chk({tag, "_empty"}, evt_count, 0);
    endtask

    initial begin
        tick();
        tick();
        chk("rst_sticky", fault_sticky, 0);
        chk("rst_valid", evt_valid, 0);
        chk("rst_shut", shutdown_req, 0);
        areset = 0;

        // single fault on index 34
        enable = 1;
        ch_sts[34] = 1;
        tick();
        chk("t1_sticky", fault_sticky, b97(34));
        chk("t1_shut", shutdown_req, 1);
        chk("t1_fv", first_valid, 1);
        chk("t1_fc", first_code, 34);
        chk("t1_noevt", evt_valid, 0);
        tick();
        chk("t1_valid", evt_valid, 1);
        chk("t1_data", evt_data, {7'd34, 32'd1});
        chk("t1_cnt", evt_count, 1);
        evt_ready = 1;
        tick();
        evt_ready = 0;
        chk("t1_pop", evt_valid, 0);
        do_clear();
        chk("t1_clr_st", fault_sticky, 0);
        chk("t1_clr_sh", shutdown_req, 0);
        chk("t1_clr_fv", first_valid, 0);

        // simultaneous rises 96, 5, 17
        ch_sts[5] = 1;
        ch_sts[17] = 1;
        bad_trig_cmd = 1;
        tick();
        a = ts_m;
        chk("t2_fc", first_code, 5);
        chk("t2_sticky", fault_sticky, b97(5) | b97(17) | b97(96));
        evt_ready = 1;
        tick();
        chk("t2_e0", evt_data, {7'd5, 32'(a)});
        tick();
        chk("t2_e1", evt_data, {7'd17, 32'(a + 1)});
        tick();
        chk("t2_e2", evt_data, {7'd96, 32'(a + 2)});
        tick();
        chk("t2_done", evt_valid, 0);
        evt_ready = 0;
        ch_sts = '0;
        bad_trig_cmd = 0;
        tick();
        do_clear();

        // 20 rises into a 16-deep FIFO with the consumer stalled
        ch_sts[19:0] = 20'hFFFFF;
        tick();
        for (int i = 0; i < 20; i++) tick();
        chk("t3_sat", evt_count, 16);
        chk("t3_lost", evt_lost, 0);
        chk("t3_sticky", fault_sticky, {77'd0, 20'hFFFFF});
        exp_q = {};
        for (int i = 0; i < 20; i++) exp_q.push_back(i);
        drain("t3_code");
        chk("t3_lost2", evt_lost, 0);
        ch_sts = '0;
        tick();
        do_clear();

        // merged rise on pending index 7 sets evt_lost
        ch_sts[23:8] = 16'hFFFF;
        tick();
        for (int i = 0; i < 18; i++) tick();
        chk("t5_full", evt_count, 16);
        ch_sts[7] = 1;
        tick();
        chk("t5_nolost", evt_lost, 0);
        ch_sts[7] = 0;
        tick();
        ch_sts[7] = 1;
        tick();
        chk("t5_lost", evt_lost, 1);
        chk("t5_full2", evt_count, 16);
        exp_q = {};
        for (int i = 8; i < 24; i++) exp_q.push_back(i);
        exp_q.push_back(7);
        drain("t5_code");
        do_clear();
        chk("t5_c_st", fault_sticky, 0);
        chk("t5_c_lost", evt_lost, 0);
        chk("t5_c_fv", first_valid, 0);
        chk("t5_c_cnt", evt_count, 0);
        chk("t5_c_sh", shutdown_req, 0);
        ch_sts = '0;
        tick();
        do_clear();

        // arming: held-high bit and spi_off rise are ignored
        enable = 0;
        ch_sts[40] = 1;
        tick();
        enable = 1;
        tick();
        tick();
        chk("t4_held", fault_sticky, 0);
        chk("t4_held_c", evt_count, 0);
        spi_off = 1;
        ch_sts[41] = 1;
        tick();
        tick();
        chk("t4_off", fault_sticky, 0);
        chk("t4_off_v", evt_valid, 0);
        spi_off = 0;
        tick();
        ch_sts[40] = 0;
        tick();
        ch_sts[40] = 1;
        tick();
        a = ts_m;
        chk("t4_rearm", fault_sticky, b97(40));
        tick();
        chk("t4_evt", evt_data, {7'd40, 32'(a)});
        evt_ready = 1;
        tick();
        evt_ready = 0;
        do_clear();

        // clear coincident with a rise on 50
        ch_sts[60] = 1;
        tick();
        tick();
        chk("t6_pre", evt_count, 1);
        clear = 1;
        ch_sts[50] = 1;
        tick();
        clear = 0;
        chk("t6_sticky", fault_sticky, b97(50));
        chk("t6_fc", first_code, 50);
        chk("t6_cnt", evt_count, 0);
        chk("t6_sh", shutdown_req, 1);
        tick();
        chk("t6_evt", evt_data[38:32], 50);
        ch_sts[73:70] = 4'hF;
        tick();
        tick();
        chk("t6_cnt2", evt_count, 2);

        // asynchronous reset mid-drain
        #1;
        areset = 1;
        #1;
        chk("ar_sticky", fault_sticky, 0);
        chk("ar_sh", shutdown_req, 0);
        chk("ar_fv", first_valid, 0);
        chk("ar_fc", first_code, 0);
        chk("ar_valid", evt_valid, 0);
        chk("ar_data", evt_data, 0);
        chk("ar_cnt", evt_count, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
